// File: rtl/mini_spi_pkg.sv
// ---------------------------------------------------------------------------
// mini_spi_pkg : shared types and defaults for the Mini_SPI main controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mini_spi_pkg;

  localparam int SPI_DEFAULT_WIDTH   = 8;
  localparam int SPI_DEFAULT_CLK_DIV = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_main_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_sclk_gen.sv
// ---------------------------------------------------------------------------
// spi_sclk_gen : half-period tick generator and sclk toggle for the SPI main
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_sclk_gen
  import mini_spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic clear,
  input  logic en,
  input  logic toggle_en,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sclk
);

  localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;

  always_comb begin
    tick   = en && (cnt_q == CNT_MAX);
    rise   = tick && toggle_en && !sclk_q;
    fall   = tick && toggle_en && sclk_q;
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    // Held cleared while disabled so every frame starts on a fresh half-period.
    if (!en) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick && toggle_en) sclk_d = !sclk_q;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

`default_nettype wire

// File: rtl/spi_main_ctrl.sv
// ---------------------------------------------------------------------------
// spi_main_ctrl : SPI mode-0 main frame controller with valid/ready word I/O
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_main_ctrl
  import mini_spi_pkg::*;
#(
  parameter int WIDTH   = SPI_DEFAULT_WIDTH,
  parameter int CLK_DIV = SPI_DEFAULT_CLK_DIV
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             cs_n,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);

  localparam int             BCW      = $clog2(WIDTH) + 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  spi_main_state_t  state_q, state_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;
  logic             rx_valid_q, rx_valid_d;

  logic gen_en, gen_tick, gen_rise, gen_fall;

  assign gen_en = (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .clear     (clear),
    .en        (gen_en),
    .toggle_en (state_q == XFER),
    .tick      (gen_tick),
    .rise      (gen_rise),
    .fall      (gen_fall),
    .sclk      (sclk)
  );

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          tx_sr_d   = tx_data;
          rx_sr_d   = '0;
          bit_cnt_d = '0;
          cs_n_d    = 1'b0;
          mosi_d    = tx_data[WIDTH-1];
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (gen_tick) state_d = XFER;
      end
      XFER: begin
        if (gen_rise) rx_sr_d = {rx_sr_q[WIDTH-2:0], miso};
        // The final falling edge leaves mosi on the last bit.
        if (gen_fall) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_sr_d   = tx_sr_q << 1;
            mosi_d    = tx_sr_q[WIDTH-2];
          end
        end
      end
      HOLD: begin
        if (gen_tick) begin
          cs_n_d     = 1'b1;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q    <= IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign cs_n     = cs_n_q;
  assign mosi     = mosi_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_main_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_main_ctrl : directed bench for spi_main_ctrl (default and 16b/div1)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_main_ctrl;

  logic clk = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  // DUT A: defaults (WIDTH=8, CLK_DIV=2)
  logic [7:0]  a_tx_data = '0;
  logic        a_tx_valid = 1'b0;
  logic        a_tx_ready, a_rx_valid, a_cs_n, a_sclk, a_mosi, a_miso;
  logic [7:0]  a_rx_data;

  // DUT B: WIDTH=16, CLK_DIV=1, loopback
  logic [15:0] b_tx_data = '0;
  logic        b_tx_valid = 1'b0;
  logic        b_tx_ready, b_rx_valid, b_cs_n, b_sclk, b_mosi;
  logic [15:0] b_rx_data;

  // Servant model: presents 0x3C, shifting on sclk falling edges
  logic [7:0]  srv_sr = 8'h3C;
  logic        sel_srv = 1'b0;
  always @(negedge a_sclk or posedge a_cs_n) begin
    if (a_cs_n) srv_sr <= 8'h3C;
    else        srv_sr <= {srv_sr[6:0], 1'b0};
  end
  assign a_miso = sel_srv ? srv_sr[7] : a_mosi;

  spi_main_ctrl u_dut_a (
    .clk      (clk),
    .clear    (clear),
    .tx_data  (a_tx_data),
    .tx_valid (a_tx_valid),
    .tx_ready (a_tx_ready),
    .rx_data  (a_rx_data),
    .rx_valid (a_rx_valid),
    .cs_n     (a_cs_n),
    .sclk     (a_sclk),
    .mosi     (a_mosi),
    .miso     (a_miso)
  );

  spi_main_ctrl #(.WIDTH(16), .CLK_DIV(1)) u_dut_b (
    .clk      (clk),
    .clear    (clear),
    .tx_data  (b_tx_data),
    .tx_valid (b_tx_valid),
    .tx_ready (b_tx_ready),
    .rx_data  (b_rx_data),
    .rx_valid (b_rx_valid),
    .cs_n     (b_cs_n),
    .sclk     (b_sclk),
    .mosi     (b_mosi),
    .miso     (b_mosi)
  );

  // Monitor on the selected DUT, sampled on the falling clk edge
  logic        sel = 1'b0;
  logic        mon_rst = 1'b1;
  logic        m_cs_n, m_sclk, m_mosi, m_rx_valid;
  logic [15:0] m_rx_data;
  assign m_cs_n     = sel ? b_cs_n     : a_cs_n;
  assign m_sclk     = sel ? b_sclk     : a_sclk;
  assign m_mosi     = sel ? b_mosi     : a_mosi;
  assign m_rx_valid = sel ? b_rx_valid : a_rx_valid;
  assign m_rx_data  = sel ? b_rx_data  : {8'h00, a_rx_data};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          rises, cs_low, cs_low_last, cs_start, gap, gap_last;
  int          rv_cnt, rv_t0, rv_t1, last_rise, sclk_per;
  logic        seen_low, mosi_all_hi, sclk_prev;
  logic [15:0] mosi_seq;
  logic [15:0] rx_hist [4];

  always @(negedge clk) begin
    if (mon_rst) begin
      rises = 0; cs_low = 0; cs_low_last = 0; cs_start = 0; gap = 0; gap_last = 0;
      rv_cnt = 0; rv_t0 = 0; rv_t1 = 0; last_rise = 0; sclk_per = 0;
      seen_low = 1'b0; mosi_all_hi = 1'b1; sclk_prev = 1'b0; mosi_seq = '0;
      for (int i = 0; i < 4; i++) rx_hist[i] = '0;
    end else begin
      if (!m_cs_n) begin
        if (cs_low == 0) cs_start = cyc;
        cs_low++;
        seen_low = 1'b1;
        if (!m_mosi) mosi_all_hi = 1'b0;
        if (gap != 0) begin gap_last = gap; gap = 0; end
      end else begin
        if (cs_low != 0) begin cs_low_last = cs_low; cs_low = 0; end
        if (seen_low) gap++;
      end
      if (m_sclk && !sclk_prev) begin
        rises++;
        mosi_seq = {mosi_seq[14:0], m_mosi};
        if (last_rise != 0) sclk_per = cyc - last_rise;
        last_rise = cyc;
      end
      sclk_prev = m_sclk;
      if (m_rx_valid) begin
        if (rv_cnt == 0) rv_t0 = cyc;
        else             rv_t1 = cyc;
        if (rv_cnt < 4) rx_hist[rv_cnt] = m_rx_data;
        rv_cnt++;
      end
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    mon_rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 mon_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_rv(input string tag, input int bound);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (m_rx_valid) begin ok = 1'b1; break; end
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int nr;
    logic sp;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cs_n",     {31'd0, a_cs_n},     32'd1);
    chk("rst_sclk",     {31'd0, a_sclk},     32'd0);
    chk("rst_mosi",     {31'd0, a_mosi},     32'd0);
    chk("rst_rx_valid", {31'd0, a_rx_valid}, 32'd0);
    chk("rst_rx_data",  {24'd0, a_rx_data},  32'd0);
    chk("rst_tx_ready", {31'd0, a_tx_ready}, 32'd1);
    chk("rst_b_cs_n",   {31'd0, b_cs_n},     32'd1);
    clear = 1'b1;

    // 1: loopback 0xA5
    mreset();
    a_tx_data = 8'hA5; a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
    wait_rv("t1_rv_timeout", 60);
    chk("t1_rx_data",        {24'd0, a_rx_data},  32'hA5);
    chk("t1_ready_in_done",  {31'd0, a_tx_ready}, 32'd0);
    @(negedge clk);
    chk("t1_rv_one_cycle",   {31'd0, a_rx_valid}, 32'd0);
    chk("t1_ready_after_rv", {31'd0, a_tx_ready}, 32'd1);
    repeat (2) @(negedge clk);
    chk("t1_sclk_rises",  rises,            32'd8);
    chk("t1_mosi_seq",    {16'd0, mosi_seq}, 32'h00A5);
    chk("t1_cs_low",      cs_low_last,      32'd36);
    chk("t1_rv_latency",  rv_t0 - cs_start, 32'd36);
    chk("t1_rv_count",    rv_cnt,           32'd1);

    // 2: servant drives 0x3C, tx 0xFF
    sel_srv = 1'b1;
    mreset();
    a_tx_data = 8'hFF; a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
    wait_rv("t2_rv_timeout", 60);
    chk("t2_rx_data", {24'd0, a_rx_data}, 32'h3C);
    repeat (2) @(negedge clk);
    chk("t2_mosi_high", {31'd0, mosi_all_hi}, 32'd1);
    chk("t2_sclk_rises", rises, 32'd8);
    sel_srv = 1'b0;

    // 3: back-to-back 0x01 then 0x80
    mreset();
    a_tx_data = 8'h01; a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_data = 8'h80;
    wait_rv("t3_rv0_timeout", 60);
    chk("t3_rx0", {24'd0, a_rx_data}, 32'h01);
    repeat (2) @(negedge clk);
    a_tx_valid = 1'b0;
    chk("t3_second_accepted", {31'd0, a_tx_ready}, 32'd0);
    wait_rv("t3_rv1_timeout", 60);
    chk("t3_rx1", {24'd0, a_rx_data}, 32'h80);
    repeat (2) @(negedge clk);
    chk("t3_rv_count",   rv_cnt,        32'd2);
    chk("t3_rv_spacing", rv_t1 - rv_t0, 32'd38);
    chk("t3_cs_gap",     gap_last,      32'd2);
    chk("t3_hist0",      {16'd0, rx_hist[0]}, 32'h01);
    chk("t3_hist1",      {16'd0, rx_hist[1]}, 32'h80);

    // 4: clear after the 4th sclk rise
    mreset();
    a_tx_data = 8'hC3; a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
    nr = 0; sp = 1'b0;
    for (int i = 0; i < 100 && nr < 4; i++) begin
      @(negedge clk);
      if (a_sclk && !sp) nr++;
      sp = a_sclk;
    end
    chk("t4_four_rises", nr, 32'd4);
    clear = 1'b0;
    #1;
    chk("t4_cs_n",     {31'd0, a_cs_n},     32'd1);
    chk("t4_sclk",     {31'd0, a_sclk},     32'd0);
    chk("t4_mosi",     {31'd0, a_mosi},     32'd0);
    chk("t4_rx_data",  {24'd0, a_rx_data},  32'd0);
    chk("t4_rx_valid", {31'd0, a_rx_valid}, 32'd0);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    chk("t4_ready", {31'd0, a_tx_ready}, 32'd1);
    repeat (50) @(negedge clk);
    chk("t4_no_rv",   rv_cnt,            32'd0);
    chk("t4_cs_idle", {31'd0, a_cs_n},   32'd1);
    a_tx_data = 8'h5A; a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
    wait_rv("t4_rv_timeout", 60);
    chk("t4_rx_data_5a", {24'd0, a_rx_data}, 32'h5A);

    // 5: 0x11 offered mid-frame of 0x22
    mreset();
    a_tx_data = 8'h22; a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    a_tx_data = 8'h11; a_tx_valid = 1'b1;
    chk("t5_busy", {31'd0, a_tx_ready}, 32'd0);
    wait_rv("t5_rv0_timeout", 60);
    chk("t5_rx0", {24'd0, a_rx_data}, 32'h22);
    repeat (2) @(negedge clk);
    a_tx_valid = 1'b0;
    wait_rv("t5_rv1_timeout", 60);
    chk("t5_rx1", {24'd0, a_rx_data}, 32'h11);
    repeat (2) @(negedge clk);
    chk("t5_rv_count", rv_cnt, 32'd2);

    // 6: WIDTH=16, CLK_DIV=1, loopback 0xBEEF
    sel = 1'b1;
    mreset();
    b_tx_data = 16'hBEEF; b_tx_valid = 1'b1;
    @(negedge clk);
    b_tx_valid = 1'b0;
    wait_rv("t6_rv_timeout", 80);
    chk("t6_rx_data", {16'd0, b_rx_data}, 32'hBEEF);
    repeat (2) @(negedge clk);
    chk("t6_cs_low",     cs_low_last,       32'd34);
    chk("t6_sclk_rises", rises,             32'd16);
    chk("t6_sclk_per",   sclk_per,          32'd2);
    chk("t6_mosi_seq",   {16'd0, mosi_seq}, 32'hBEEF);
    chk("t6_rv_latency", rv_t0 - cs_start,  32'd34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_main_ctrl.md
Name: spi_main_ctrl

Overview:
SPI main (master) frame controller for the Mini_SPI design.
- Accepts a parallel word over a valid/ready handshake.
- Generates cs_n/sclk, drives mosi MSB-first and samples miso.
- Returns the received word with a one-cycle valid pulse.
- Sits directly upstream of the servant-side shift register, which is clocked by its sclk/mosi.
- SPI mode 0 only (CPOL=0, CPHA=0).

Parameters:
- WIDTH, 8: bits per frame; legal values are 2 and above.
- CLK_DIV, 2: clk cycles per sclk half-period; legal values are 1 and above.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- clear  in  1  asynchronous, active-low reset.
- tx_data  in  WIDTH  word to transmit; sampled only on acceptance.
- tx_valid  in  1  producer has a word.
- tx_ready  out  1  high only in IDLE; a transfer is accepted when tx_valid and tx_ready are both high at a clk edge.
- rx_data  out  WIDTH  last received word; holds until the next frame completes.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- cs_n  out  1  chip select, active-low.
- sclk  out  1  serial clock; idles low.
- mosi  out  1  serial data out, MSB first.
- miso  in  1  serial data in.

Behaviour:
- Reset (clear=0, asynchronous):
  - state=IDLE, cs_n=1, sclk=0, mosi=0, rx_valid=0, rx_data=0.
  - tx_ready=1 (it is decoded from state==IDLE).
  - All counters and the tx/rx shift registers are zeroed.
- All outputs except tx_ready are registered.
- States: IDLE, SETUP, XFER, HOLD, DONE.
- IDLE:
  - On accept at edge E0: latch tx_data into tx_sr, set cs_n=0, mosi=tx_data[WIDTH-1], go to SETUP.
- SETUP:
  - Lasts CLK_DIV cycles with sclk=0 (cs_n-to-first-edge setup), then go to XFER.
- XFER: 2*WIDTH half-periods of CLK_DIV cycles each, starting with sclk low.
  - Low-to-high: sclk=1; in the same edge, rx_sr <= {rx_sr[WIDTH-2:0], miso}.
  - High-to-low: sclk=0, tx_sr shifts left, mosi <= next bit.
  - After the WIDTH-th falling edge go to HOLD; mosi holds the last bit.
- HOLD:
  - Lasts CLK_DIV cycles with cs_n=0 and sclk=0.
  - At its end: cs_n=1, rx_data<=rx_sr, rx_valid=1, go to DONE.
- DONE:
  - Lasts one cycle: rx_valid=1, tx_ready=0, then go to IDLE.
  - rx_valid returns to 0 on the next edge.
- Timing:
  - cs_n is low for exactly CLK_DIV*(2*WIDTH+2) cycles, i.e. 36 at the defaults.
  - rx_valid rises at edge E0+CLK_DIV*(2*WIDTH+2).
  - tx_ready rises one cycle after rx_valid.
  - Each sclk rising edge is preceded by mosi stable for ≥CLK_DIV cycles.
- Back-to-back frames (tx_valid held high): the next frame is accepted at the first IDLE edge, so cs_n is high for exactly 2 cycles between frames.
- tx_valid while tx_ready=0 is ignored. tx_data changes mid-frame have no effect.
- miso is sampled only at sclk rising edges. Its value at other times is don't-care.
- Reset mid-frame:
  - Outputs return immediately to their reset values, so the frame is aborted with cs_n=1.
  - No rx_valid is produced and rx_data is zeroed.
- Counters: a half-period counter of width clog2(CLK_DIV) wraps at CLK_DIV-1; a bit counter of width clog2(WIDTH)+1. No counter exceeds its range.

Decomposition:
- Package mini_spi_pkg:
  - State enum spi_main_state_t (IDLE, SETUP, XFER, HOLD, DONE).
  - Constants SPI_DEFAULT_WIDTH=8 and SPI_DEFAULT_CLK_DIV=2.
- One sub-module, spi_sclk_gen:
  - Half-period counter that issues a tick every CLK_DIV cycles while enabled.
  - Toggles sclk and flags rise/fall events to the FSM.
  - Held in reset while in IDLE.

Test Plan:
1. Loopback (miso tied to mosi), tx_data=0xA5 at defaults:
   - Exactly 8 sclk rising edges.
   - mosi sequence 1,0,1,0,0,1,0,1.
   - cs_n low 36 cycles.
   - rx_valid one cycle at E0+36 with rx_data=0xA5.
2. Servant model drives miso 0x3C (changing on sclk falling edges), tx_data=0xFF:
   - rx_data=0x3C.
   - mosi high throughout the frame.
3. tx_valid held high with 0x01 then 0x80:
   - Two frames, cs_n high exactly 2 cycles between them.
   - rx_valid pulses 38 cycles apart.
   - Loopback rx_data 0x01 then 0x80.
4. clear pulsed low just after the 4th sclk rising edge:
   - cs_n=1, sclk=0, mosi=0 immediately.
   - No rx_valid.
   - tx_ready=1 after release; the next frame with 0x5A completes correctly.
5. tx_valid asserted with 0x11 mid-frame of 0x22 (tx_ready=0):
   - The 0x11 is ignored until IDLE.
   - Completed frames are 0x22 then 0x11 (loopback).
6. CLK_DIV=1, WIDTH=16, tx_data=0xBEEF loopback:
   - cs_n low 34 cycles.
   - sclk period 2 cycles.
   - rx_data=0xBEEF.
